hit_event_monitor: RTL and testbench
====================================

HIT_EVENT_MONITOR -- requirements
Module: hit_event_monitor

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8: minimum number of cycles alarm stays high (>=1).
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 4: number of alarm-low cycles spent in cooldown after an alarm (>=1).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: number of timestamp entries stored (power of 2, >=2).
REQ-004 SHALL have parameter TS_W, default 16: timestamp width in bits.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port hit, input, 1 bit: single-cycle threshold-crossing pulse from the upstream sequence checker, synchronous to clk.
REQ-008 SHALL have port ack, input, 1 bit: alarm acknowledge from software/host.
REQ-009 SHALL have port evt_ready, input, 1 bit: consumer ready for the event stream.
REQ-010 SHALL have port evt_valid, output, 1 bit: FIFO non-empty.
REQ-011 SHALL have port evt_ts, output, TS_W bits: timestamp at the FIFO head.
REQ-012 SHALL have port alarm, output, 1 bit: alarm level.
REQ-013 SHALL have port drop_cnt, output, 8 bits: count of hits lost to FIFO overflow.

Function
REQ-014 SHALL run a free-running timestamp counter ts: +1 every cycle, wrapping from 2^TS_W-1 to 0.
REQ-015 SHALL push the current ts value into the FIFO on every edge where hit=1; evt_valid=1 and evt_ts=pushed value SHALL be visible in the cycle after that edge (1-cycle latency, first-word-fall-through).
REQ-016 SHALL pop the head on an edge where evt_valid=1 and evt_ready=1; evt_ready SHALL be ignored when evt_valid=0.
REQ-017 SHALL, when the FIFO is full and a push and a pop occur on the same edge, perform both with no drop and occupancy unchanged.
REQ-018 SHALL, when the FIFO is full and a push occurs without a pop, discard the new entry and increment drop_cnt, saturating at 255.
REQ-019 SHALL keep evt_ts stable while evt_valid=1 and evt_ready=0.
REQ-020 SHALL deliver entries in push order, with FIFO pointers wrapping modulo FIFO_DEPTH.
REQ-021 SHALL implement FSM states IDLE, ALARM and COOLDOWN; alarm=1 only in ALARM.
REQ-022 SHALL, in IDLE, transition to ALARM on an edge with hit=1 and load the hold counter with HOLD_CYCLES-1; alarm SHALL rise in the cycle after the hit edge.
REQ-023 SHALL, in ALARM, reload the hold counter with HOLD_CYCLES-1 on any hit, and otherwise decrement it to 0.
REQ-024 SHALL, in ALARM, latch ack=1 into ack_seen; ack SHALL be ignored in IDLE and COOLDOWN.
REQ-025 SHALL leave ALARM for COOLDOWN on an edge where the hold counter is 0, no hit is present, and either ack_seen=1 or ack=1; this clears ack_seen and loads the cooldown counter with COOLDOWN_CYCLES-1.
REQ-026 SHALL count down in COOLDOWN and go to IDLE on the edge where the cooldown counter is 0; a hit in COOLDOWN SHALL be logged to the FIFO but SHALL NOT re-enter ALARM.
REQ-027 SHALL keep alarm high for at least HOLD_CYCLES consecutive cycles per alarm episode, and indefinitely while no ack arrives.
REQ-028 SHALL keep FIFO logging independent of FSM state.

Reset
REQ-029 SHALL, while rst=1 (asynchronously, including mid-operation), force: ts=0, FIFO empty, evt_valid=0, evt_ts=0, alarm=0, drop_cnt=0, state=IDLE, ack_seen=0, all counters 0.
REQ-030 SHALL ignore a hit on the first edge after rst deasserts only if it coincides with rst=1; any hit on a later edge SHALL be processed normally.

Verification (defaults: HOLD=8, COOLDOWN=4, DEPTH=4, TS_W=16)
REQ-031 SHALL cover: after reset, hit on the edge where ts=5 -> next cycle alarm=1, evt_valid=1, evt_ts=5.
REQ-032 SHALL cover: ack pulse in the 2nd ALARM cycle, no further hits -> alarm high exactly 8 cycles, then low for 4 COOLDOWN cycles, then IDLE; a hit in cycle 3 of COOLDOWN is queued and alarm stays 0.
REQ-033 SHALL cover: no ack -> alarm stays high for 50+ cycles; a hit in ALARM cycle 6 extends the minimum to 6+8 cycles.
REQ-034 SHALL cover: evt_ready=0 with 6 hits at ts=10..15 -> 4 entries 10,11,12,13 and drop_cnt=2; then evt_ready=1 -> pops 10,11,12,13 in order, then evt_valid=0.
REQ-035 SHALL cover: FIFO full, hit and pop on the same edge -> drop_cnt unchanged and occupancy stays 4; ts wraps 65535->0 and a hit at ts=0 logs 0.
REQ-036 SHALL cover: rst asserted mid-ALARM with 3 entries queued -> alarm, evt_valid and drop_cnt are 0 immediately (before the next clk edge), and the FIFO is empty after release.

Source files
------------

// File: rtl/hit_event_monitor.sv
// Hit event monitor: timestamps threshold hits into a small FWFT FIFO and
// raises a held, acknowledge-gated alarm with a post-alarm cooldown.
module hit_event_monitor #(
  parameter int HOLD_CYCLES     = 8,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int TS_W            = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hit,
  input  logic            ack,
  input  logic            evt_ready,
  output logic            evt_valid,
  output logic [TS_W-1:0] evt_ts,
  output logic            alarm,
  output logic [7:0]      drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ALARM    = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  // ---------------- timestamp ----------------
  logic [TS_W-1:0] ts_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + 1'b1;
    end
  end

  // ---------------- event FIFO ----------------
  logic [TS_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [AW:0]     count_next;
  logic [7:0]      drop_reg;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            wr_en;
  logic            drop;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign pop        = !fifo_empty && evt_ready;
  // A pop on the same edge frees the slot the new entry lands in.
  assign wr_en      = hit && (!fifo_full || pop);
  assign drop       = hit && fifo_full && !pop;

  always_comb begin
    count_next = count_reg;
    if (wr_en && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !wr_en) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= ts_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      drop_reg   <= '0;
    end else begin
      count_reg <= count_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (drop && (drop_reg != 8'hFF)) begin
        drop_reg <= drop_reg + 1'b1;
      end
    end
  end

  assign evt_valid = !fifo_empty;
  assign evt_ts    = fifo_empty ? '0 : mem[rd_ptr_reg];
  assign drop_cnt  = drop_reg;

  // ---------------- alarm FSM ----------------
  logic [1:0]    state_reg;
  logic [HW-1:0] hold_reg;
  logic [CW-1:0] cool_reg;
  logic          ack_seen_reg;
  logic          leave_alarm;

  assign leave_alarm = !hit && (hold_reg == '0) && (ack_seen_reg || ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_reg     <= '0;
      cool_reg     <= '0;
      ack_seen_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hit) begin
            state_reg <= ALARM;
            hold_reg  <= HOLD_LOAD;
          end
        end
        ALARM: begin
          if (leave_alarm) begin
            state_reg    <= COOLDOWN;
            ack_seen_reg <= 1'b0;
            cool_reg     <= COOL_LOAD;
          end else begin
            ack_seen_reg <= ack_seen_reg | ack;
            if (hit) begin
              hold_reg <= HOLD_LOAD;
            end else if (hold_reg != '0) begin
              hold_reg <= hold_reg - 1'b1;
            end
          end
        end
        COOLDOWN: begin
          // Hits here are still logged by the FIFO but never re-arm the alarm.
          if (cool_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            cool_reg <= cool_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign alarm = (state_reg == ALARM);

endmodule

// File: tb/tb_hit_event_monitor.sv
// Scoreboard bench for hit_event_monitor: a cycle-indexed reference model
// feeds an expected-timestamp queue that a negedge monitor checks.
module tb_hit_event_monitor;
  localparam int HOLD  = 8;
  localparam int COOL  = 4;
  localparam int DEPTH = 4;
  localparam int TSW   = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           hit = 1'b0;
  logic           ack = 1'b0;
  logic           evt_ready = 1'b0;
  logic           evt_valid;
  logic [TSW-1:0] evt_ts;
  logic           alarm;
  logic [7:0]     drop_cnt;

  hit_event_monitor #(
    .HOLD_CYCLES(HOLD), .COOLDOWN_CYCLES(COOL), .FIFO_DEPTH(DEPTH), .TS_W(TSW)
  ) dut (
    .clk(clk), .rst(rst), .hit(hit), .ack(ack), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_ts(evt_ts), .alarm(alarm), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 0;

  // Reference model: absolute edge index, alarm deadline and cooldown end.
  int m_n, m_ts, m_drop, m_active, m_acked, m_deadline, m_cool_end;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_ts = 0; m_drop = 0; m_active = 0; m_acked = 0;
    m_deadline = 0; m_cool_end = -100;
    exp_q.delete();
  endtask

  // Applies the inputs present at the edge just taken.
  task automatic model_edge();
    m_n++;
    if (hit) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(m_ts);
      else if (m_drop < 255) m_drop++;
    end
    if (m_active != 0) begin
      if (!hit && m_n >= m_deadline && (m_acked != 0 || ack)) begin
        m_active = 0;
        m_acked = 0;
        m_cool_end = m_n + COOL;
      end else begin
        if (ack) m_acked = 1;
        if (hit) m_deadline = m_n + HOLD;
      end
    end else if (m_n > m_cool_end && hit) begin
      m_active = 1;
      m_acked = 0;
      m_deadline = m_n + HOLD;
    end
    m_ts = (m_ts + 1) % (1 << TSW);
  endtask

  // Monitor: compares outputs each cycle and retires popped entries.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("alarm", int'(alarm), m_active);
      chk("evt_valid", int'(evt_valid), int'(exp_q.size() != 0));
      chk("drop_cnt", int'(drop_cnt), m_drop);
      if (exp_q.size() != 0) begin
        chk("evt_ts", int'(evt_ts), exp_q[0]);
        if (evt_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic h, input logic a, input logic r);
    hit = h; ack = a; evt_ready = r;
    @(posedge clk);
    #2;
    model_edge();
  endtask

  task automatic do_reset(input logic hit_in_rst);
    rst = 1'b1;
    #1;
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_ts", int'(evt_ts), 0);
    model_reset();
    hit = hit_in_rst; ack = 1'b0; evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    hit = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int alen;
    int cnt;
    do_reset(1'b0);
    mon_en = 1;

    // Hit at ts=5 right after reset.
    repeat (5) step(0, 0, 0);
    step(1, 0, 0);
    chk("ts5_alarm", int'(alarm), 1);
    chk("ts5_valid", int'(evt_valid), 1);
    chk("ts5_evt_ts", int'(evt_ts), 5);

    // Ack in 2nd alarm cycle: 8 high cycles, then cooldown ignores a hit.
    alen = 1;
    step(0, 0, 1); if (alarm) alen++;
    step(0, 1, 1); if (alarm) alen++;
    for (int i = 0; i < 20 && alarm; i++) begin
      step(0, 0, 1);
      if (alarm) alen++;
    end
    chk("alarm_len_ack", alen, HOLD);
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 0, 0);
    chk("cool_hit_logged", int'(evt_valid), 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1);
      chk("cool_no_alarm", int'(alarm), 0);
    end

    // Hit in alarm cycle 6 with early ack: minimum becomes 6+8.
    step(1, 0, 1);
    alen = 1;
    step(0, 1, 1); if (alarm) alen++;
    repeat (4) begin step(0, 0, 1); if (alarm) alen++; end
    step(1, 0, 1); if (alarm) alen++;
    for (int i = 0; i < 30 && alarm; i++) begin
      step(0, 0, 1);
      if (alarm) alen++;
    end
    chk("alarm_len_extend", alen, 6 + HOLD);
    repeat (6) step(0, 0, 1);

    // No ack: alarm holds indefinitely; after ack, hits rearm only after cooldown.
    step(1, 0, 1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 1);
      if (alarm) cnt++;
    end
    chk("noack_hold", cnt, 60);
    step(0, 1, 1);
    chk("ack_release", int'(alarm), 0);
    cnt = 0;
    for (int i = 0; i < 12 && !alarm; i++) begin
      step(1, 0, 1);
      cnt++;
    end
    chk("cooldown_rearm", cnt, COOL + 1);
    repeat (3) step(0, 0, 1);

    // Overflow: six hits at ts=10..15 with the consumer stalled.
    do_reset(1'b0);
    repeat (10) step(0, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 0);
    chk("ovf_drop", int'(drop_cnt), 2);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_order", int'(evt_ts), 10 + k);
      step(0, 0, 1);
    end
    chk("ovf_empty", int'(evt_valid), 0);

    // Full FIFO with simultaneous push and pop.
    repeat (4) step(1, 0, 0);
    step(1, 0, 1);
    chk("full_pushpop_drop", int'(drop_cnt), 2);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (evt_valid) cnt++;
      step(0, 0, 1);
    end
    chk("full_pushpop_occ", cnt, DEPTH);

    // Timestamp wrap.
    for (int i = 0; i < 70000 && m_ts != 65535; i++) step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("wrap_head", int'(evt_ts), 65535);
    step(0, 0, 1);
    chk("wrap_zero", int'(evt_ts), 0);
    step(0, 0, 1);
    chk("wrap_empty", int'(evt_valid), 0);

    // Asynchronous reset mid-alarm with 3 entries queued; hit during reset ignored.
    repeat (3) step(1, 0, 0);
    chk("pre_rst_alarm", int'(alarm), 1);
    chk("pre_rst_drop", int'(drop_cnt), 2);
    do_reset(1'b1);
    step(0, 0, 1);
    chk("post_rst_empty", int'(evt_valid), 0);
    chk("post_rst_alarm", int'(alarm), 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0, $urandom_range(1, 0) == 1);
    end
    step(0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
